// File: rtl/instr_encode_writer.sv
// Packs RV32I instruction fields into a 32-bit word and writes it to instruction memory
// at a self-incrementing word address, flagging out-of-range immediates and illegal formats.
module instr_encode_writer #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        in_fmt_i,
   input  logic [6:0]        in_opcode_i,
   input  logic [4:0]        in_rd_i,
   input  logic [4:0]        in_rs1_i,
   input  logic [4:0]        in_rs2_i,
   input  logic [2:0]        in_funct3_i,
   input  logic [6:0]        in_funct7_i,
   input  logic [31:0]       in_imm_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   output logic [ADDR_W:0]   count_o,
   output logic              err_range_o,
   output logic              err_fmt_o
);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StWrite = 1'b1;

   localparam logic [2:0] FmtR = 3'd0;
   localparam logic [2:0] FmtI = 3'd1;
   localparam logic [2:0] FmtS = 3'd2;
   localparam logic [2:0] FmtB = 3'd3;
   localparam logic [2:0] FmtU = 3'd4;
   localparam logic [2:0] FmtJ = 3'd5;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              err_range_q, err_range_d;
   logic              err_fmt_q, err_fmt_d;

   logic [31:0] enc;
   logic        fmt_ok;
   logic        range_ok;
   logic [31:0] imm;

   assign imm = in_imm_i;

   // Range checks are done as "upper bits are a pure sign extension" tests.
   always_comb begin
      enc      = '0;
      fmt_ok   = 1'b1;
      range_ok = 1'b1;
      case (in_fmt_i)
         FmtR: enc = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
         FmtI: begin
            enc      = {imm[11:0], in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
            range_ok = (imm[31:11] == {21{imm[31]}});
         end
         FmtS: begin
            enc      = {imm[11:5], in_rs2_i, in_rs1_i, in_funct3_i, imm[4:0], in_opcode_i};
            range_ok = (imm[31:11] == {21{imm[31]}});
         end
         FmtB: begin
            enc      = {imm[12], imm[10:5], in_rs2_i, in_rs1_i, in_funct3_i, imm[4:1], imm[11],
                        in_opcode_i};
            range_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
         end
         FmtU: begin
            enc      = {imm[31:12], in_rd_i, in_opcode_i};
            range_ok = (imm[11:0] == 12'd0);
         end
         FmtJ: begin
            enc      = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd_i, in_opcode_i};
            range_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
         end
         default: fmt_ok = 1'b0;
      endcase
   end

   assign in_ready_o = (state_q == StIdle) && !clear_i;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      count_d     = count_q;
      err_range_d = err_range_q;
      err_fmt_d   = err_fmt_q;
      case (state_q)
         StIdle: begin
            if (clear_i) begin
               addr_d      = BASE_ADDR;
               count_d     = '0;
               err_range_d = 1'b0;
               err_fmt_d   = 1'b0;
            end else if (in_valid_i) begin
               if (!fmt_ok) begin
                  err_fmt_d = 1'b1;
               end else if (!range_ok) begin
                  err_range_d = 1'b1;
               end else begin
                  wdata_d = enc;
                  state_d = StWrite;
               end
            end
         end
         default: begin
            if (mem_ack_i) begin
               addr_d  = addr_q + 1'b1;
               count_d = (count_q == '1) ? count_q : count_q + (ADDR_W + 1)'(1);
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         addr_q      <= BASE_ADDR;
         wdata_q     <= '0;
         count_q     <= '0;
         err_range_q <= 1'b0;
         err_fmt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         count_q     <= count_d;
         err_range_q <= err_range_d;
         err_fmt_q   <= err_fmt_d;
      end
   end

   assign mem_we_o    = (state_q == StWrite);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign count_o     = count_q;
   assign err_range_o = err_range_q;
   assign err_fmt_o   = err_fmt_q;

endmodule

// File: doc/instr_encode_writer.md
# instr_encode_writer

Builds RV32I instruction words from separate fields: opcode, registers, funct bits and a full-width signed immediate. It packs the immediate into the I/S/B/U/J bit layout the core's immediate generator expects. Each encoded word is written to instruction memory at a self-incrementing address. It sits on the test/boot path beside instruction memory and loads programs into the CPU without a hex file.

## Interface
Parameters:
- ADDR_W, 8, width of the word address into instruction memory.
- BASE_ADDR, 0, word address loaded by reset and by `clear`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: address, count and error flags return to reset values.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_fmt  in  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  in  7  opcode field.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  signed immediate value (the byte offset or full value, not pre-shifted).
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  encoded instruction.
- mem_ack  in  1  memory accepted the write this cycle.
- count  out  ADDR_W+1  number of words written since reset/clear; saturates at all-ones.
- err_range  out  1  sticky: an immediate was out of range or misaligned.
- err_fmt  out  1  sticky: an illegal in_fmt was received.

## Operation
State machine: IDLE, WRITE.

- **IDLE**
  - in_ready = !clear.
  - If clear: address=BASE_ADDR, count=0, errors=0; no request is accepted.
  - If in_valid && in_ready: check and encode the request.
    - Legal request: the encoded word is registered into mem_wdata and the state moves to WRITE.
    - Illegal request: set the matching sticky flag, drop the request, stay in IDLE.
- **WRITE**
  - mem_we=1; mem_addr and mem_wdata are held stable.
  - On mem_ack: address increments, count increments (saturating), state returns to IDLE.
  - clear is ignored in WRITE; it must still be high in IDLE to take effect.

Encoding (bit 31 down to bit 0):
- R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
- I: imm[11:0] | rs1 | funct3 | rd | opcode.
- S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
- B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
- U: imm[31:12] | rd | opcode.
- J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.

Range checks (failure sets err_range and nothing is written):
- I, S: -2048..2047.
- B: -4096..4094, and imm[0]=0.
- U: imm[11:0]=0.
- J: -1048576..1048574, and imm[0]=0.
- R: in_imm is ignored.

Other rules:
- Address wrap: mem_addr increments modulo 2^ADDR_W. The wrap itself is not flagged; count keeps counting up to saturation.
- Fields are not validated beyond the checks above. in_opcode is passed through unchanged.

## Timing
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err_range=0, err_fmt=0.
- Handshake at edge T → mem_we=1 with the final mem_wdata from T+1. There is no combinational path from the in_* inputs to the mem_* outputs.
- mem_ack high in the first WRITE cycle → in_ready=1 again one cycle later. Peak throughput is one word per 2 cycles.
- mem_ack low → WRITE is held indefinitely with all outputs stable.
- An illegal request costs one cycle: the flag is visible the cycle after the handshake and in_ready stays 1.
- rst asserted mid-WRITE → mem_we drops asynchronously; the partial write is abandoned and the address is not advanced.
- mem_ack in IDLE is ignored.

## Test plan
- Reset, then send I, op=0010011, rd=1, rs1=0, f3=0, imm=5 (ack immediate) → mem_wdata=0x00500093 at addr 0; count=1; in_ready high two cycles after the handshake.
- Send in sequence, acks immediate:
  - S: op=0100011, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423 at addr 1.
  - B: op=1100011, rs1=1, rs2=2, f3=0, imm=-8 → 0xFE208CE3 at addr 2.
  - J: op=1101111, rd=1, imm=2048 → 0x001000EF at addr 3.
  - U: op=0110111, rd=5, imm=0x12345000 → 0x123452B7 at addr 4.
- Illegal requests, one each:
  - I with imm=2048 → err_range=1, no mem_we, count unchanged.
  - B with imm=6 (legal) → written; B with imm=3 → err_range stays 1, not written.
  - in_fmt=6 → err_fmt=1, nothing written.
- Hold mem_ack low 5 cycles during WRITE → mem_we, mem_addr and mem_wdata stable, in_ready=0 throughout. Ack on cycle 6 → address advances once.
- ADDR_W=2: write 5 words → addresses 0,1,2,3,0; count=5.
- Edge cases:
  - Pulse clear during WRITE → ignored; the write completes at its address.
  - Pulse clear in IDLE → mem_addr=BASE_ADDR, count=0, errors cleared.
  - Assert rst mid-WRITE → mem_we=0 immediately and all outputs at their reset values.
